// File: rtl/fetch_queue.sv
// Instruction fetch queue: presents a line-aligned lookup address to the I-cache,
// splits each 64-bit hit line into two instructions and buffers them with their PCs.
module fetch_queue #(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] NOOP_INST   = 32'h47FF041F
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [63:0]                    Icache_data_out,
    input  logic                           Icache_valid_out,
    input  logic                           rollback_en,
    input  logic [63:0]                    rollback_pc,
    input  logic                           dispatch_en,
    output logic [63:0]                    proc2Icache_addr,
    output logic [31:0]                    inst_out,
    output logic [63:0]                    inst_pc_out,
    output logic                           inst_valid_out,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [63:0]      fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      inst_mem [QUEUE_DEPTH];
    logic [63:0]      pc_mem   [QUEUE_DEPTH];

    logic [CNT_W-1:0] n_enq;
    logic [CNT_W-1:0] room;
    logic [CNT_W-1:0] tail_sum;
    logic [PTR_W-1:0] tail_plus1;
    logic             enq;
    logic             deq;

    // Room check deliberately uses the pre-dequeue count (conservative).
    always_comb begin
        n_enq      = fetch_pc[2] ? CNT_W'(1) : CNT_W'(2);
        room       = CNT_W'(QUEUE_DEPTH) - count;
        enq        = Icache_valid_out && !rollback_en && (room >= n_enq);
        deq        = dispatch_en && (count != '0) && !rollback_en;
        tail_sum   = {1'b0, tail} + n_enq;
        tail_plus1 = tail + PTR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (rollback_en) begin
            fetch_pc <= {rollback_pc[63:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                if (fetch_pc[2]) begin
                    inst_mem[tail] <= Icache_data_out[63:32];
                    pc_mem[tail]   <= fetch_pc;
                end else begin
                    inst_mem[tail]       <= Icache_data_out[31:0];
                    pc_mem[tail]         <= fetch_pc;
                    inst_mem[tail_plus1] <= Icache_data_out[63:32];
                    pc_mem[tail_plus1]   <= fetch_pc + 64'd4;
                end
                tail     <= tail_sum[PTR_W-1:0];
                fetch_pc <= {fetch_pc[63:3] + 61'd1, 3'b000};
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count <= count + (enq ? n_enq : '0) - (deq ? CNT_W'(1) : '0);
        end
    end

    always_comb begin
        proc2Icache_addr = {fetch_pc[63:3], 3'b000};
        inst_valid_out   = (count != '0);
        queue_count      = count;
        inst_out         = inst_valid_out ? inst_mem[head] : NOOP_INST;
        inst_pc_out      = inst_valid_out ? pc_mem[head]   : 64'd0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: hand-computed vectors plus a small FIFO model for wrap runs.
module tb_fetch_queue;

    localparam logic [31:0] NOOP = 32'h47FF041F;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic        rollback_en;
    logic [63:0] rollback_pc;
    logic        dispatch_en;
    logic [63:0] proc2Icache_addr;
    logic [31:0] inst_out;
    logic [63:0] inst_pc_out;
    logic        inst_valid_out;
    logic [3:0]  queue_count;

    int n_cmp = 0;
    int n_mis = 0;

    logic [95:0] model_q[$];
    logic [63:0] model_addr;

    fetch_queue #(.QUEUE_DEPTH(8), .NOOP_INST(NOOP)) dut (
        .clock            (clock),
        .reset            (reset),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .rollback_en      (rollback_en),
        .rollback_pc      (rollback_pc),
        .dispatch_en      (dispatch_en),
        .proc2Icache_addr (proc2Icache_addr),
        .inst_out         (inst_out),
        .inst_pc_out      (inst_pc_out),
        .inst_valid_out   (inst_valid_out),
        .queue_count      (queue_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        Icache_valid_out = 1'b0;
        dispatch_en      = 1'b0;
        rollback_en      = 1'b0;
    endtask

    function automatic logic [63:0] mk_line(input logic [63:0] a);
        return {32'hA500_0000 ^ (a[31:0] + 32'd4), 32'hA500_0000 ^ a[31:0]};
    endfunction

    task automatic check_model(input string tag);
        logic [95:0] h;
        check_val({tag, "_cnt"}, 64'(queue_count), 64'(model_q.size()));
        check_val({tag, "_addr"}, proc2Icache_addr, model_addr);
        if (model_q.size() == 0) begin
            check_val({tag, "_inst"}, 64'(inst_out), 64'(NOOP));
            check_val({tag, "_vld"}, 64'(inst_valid_out), 64'd0);
        end else begin
            h = model_q[0];
            check_val({tag, "_inst"}, 64'(inst_out), 64'(h[95:64]));
            check_val({tag, "_pc"}, inst_pc_out, h[63:0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_vld"}, 64'(inst_valid_out), 64'd0);
        check_val({tag, "_inst"}, 64'(inst_out), 64'(NOOP));
        check_val({tag, "_pc"}, inst_pc_out, 64'd0);
        check_val({tag, "_cnt"}, 64'(queue_count), 64'd0);
        check_val({tag, "_addr"}, proc2Icache_addr, 64'd0);
    endtask

    initial begin
        logic acc;
        logic dq;
        logic [63:0] line;

        idle_inputs();
        Icache_data_out = '0;
        rollback_pc     = '0;
        reset           = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_outputs("rst");

        // Aligned hit at pc 0, then one dispatch
        Icache_valid_out = 1'b1;
        Icache_data_out  = 64'hAAAA_AAAA_BBBB_BBBB;
        step();
        idle_inputs();
        check_val("t1_inst", 64'(inst_out), 64'hBBBB_BBBB);
        check_val("t1_pc", inst_pc_out, 64'd0);
        check_val("t1_cnt", 64'(queue_count), 64'd2);
        check_val("t1_addr", proc2Icache_addr, 64'd8);
        dispatch_en = 1'b1;
        step();
        idle_inputs();
        check_val("t1_inst2", 64'(inst_out), 64'hAAAA_AAAA);
        check_val("t1_pc2", inst_pc_out, 64'd4);
        check_val("t1_cnt2", 64'(queue_count), 64'd1);

        // Rollback to an unaligned-in-line PC: only the high word is taken
        rollback_en = 1'b1;
        rollback_pc = 64'h104;
        step();
        idle_inputs();
        check_val("t2_cnt0", 64'(queue_count), 64'd0);
        check_val("t2_vld0", 64'(inst_valid_out), 64'd0);
        check_val("t2_addr0", proc2Icache_addr, 64'h100);
        Icache_valid_out = 1'b1;
        Icache_data_out  = 64'h1111_1111_2222_2222;
        step();
        idle_inputs();
        check_val("t2_cnt", 64'(queue_count), 64'd1);
        check_val("t2_inst", 64'(inst_out), 64'h1111_1111);
        check_val("t2_pc", inst_pc_out, 64'h104);
        check_val("t2_addr", proc2Icache_addr, 64'h108);

        // Fill to full with aligned lines from pc 0
        rollback_en = 1'b1;
        rollback_pc = 64'h0;
        step();
        idle_inputs();
        model_q.delete();
        model_addr = 64'h0;
        for (int i = 0; i < 5; i++) begin
            line = mk_line(model_addr);
            Icache_valid_out = 1'b1;
            Icache_data_out  = line;
            acc = (8 - model_q.size()) >= 2;
            step();
            if (acc) begin
                model_q.push_back({line[31:0], model_addr});
                model_q.push_back({line[63:32], model_addr + 64'd4});
                model_addr += 64'd8;
            end
            check_model("t3_fill");
        end
        check_val("t3_full", 64'(queue_count), 64'd8);
        check_val("t3_frozen", proc2Icache_addr, 64'h20);

        // Full + hit + dispatch: dequeue only
        Icache_data_out = mk_line(64'h20);
        dispatch_en = 1'b1;
        step();
        check_val("t4_cnt7", 64'(queue_count), 64'd7);
        check_val("t4_addr7", proc2Icache_addr, 64'h20);
        check_val("t4_pc7", inst_pc_out, 64'h4);
        // count 7, aligned hit, no dispatch: needs 2 slots, stalls
        dispatch_en = 1'b0;
        step();
        check_val("t3_stall7_cnt", 64'(queue_count), 64'd7);
        check_val("t3_stall7_addr", proc2Icache_addr, 64'h20);
        // count 7 + dispatch: room by pre-dequeue count is 1, still stalls
        dispatch_en = 1'b1;
        step();
        check_val("t4_cnt6", 64'(queue_count), 64'd6);
        check_val("t4_addr6", proc2Icache_addr, 64'h20);
        check_val("t4_pc6", inst_pc_out, 64'h8);
        // count 6 + dispatch: room 2, accepted
        step();
        idle_inputs();
        check_val("t4_cnt_acc", 64'(queue_count), 64'd7);
        check_val("t4_addr_acc", proc2Icache_addr, 64'h28);
        check_val("t4_pc_acc", inst_pc_out, 64'hC);
        check_val("t4_inst_acc", 64'(inst_out), 64'(32'hA500_0000 ^ 32'hC));

        // Drain to 5, then rollback with simultaneous hit and dispatch
        dispatch_en = 1'b1;
        step();
        step();
        idle_inputs();
        check_val("t5_cnt5", 64'(queue_count), 64'd5);
        rollback_en      = 1'b1;
        rollback_pc      = 64'h2003;
        Icache_valid_out = 1'b1;
        dispatch_en      = 1'b1;
        Icache_data_out  = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        idle_inputs();
        check_val("t5_cnt", 64'(queue_count), 64'd0);
        check_val("t5_vld", 64'(inst_valid_out), 64'd0);
        check_val("t5_inst", 64'(inst_out), 64'(NOOP));
        check_val("t5_pc", inst_pc_out, 64'd0);
        check_val("t5_addr", proc2Icache_addr, 64'h2000);

        // Mixed fill/drain so pointers wrap several times
        model_q.delete();
        model_addr = 64'h2000;
        for (int i = 0; i < 48; i++) begin
            line = mk_line(model_addr);
            Icache_valid_out = (i % 3) != 2;
            dispatch_en      = (i % 4) != 0;
            Icache_data_out  = line;
            acc = Icache_valid_out && ((8 - model_q.size()) >= 2);
            dq  = dispatch_en && (model_q.size() > 0);
            step();
            if (dq) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back({line[31:0], model_addr});
                model_q.push_back({line[63:32], model_addr + 64'd4});
                model_addr += 64'd8;
            end
            check_model("t6_mix");
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            dispatch_en = 1'b1;
            dq = model_q.size() > 0;
            step();
            if (dq) void'(model_q.pop_front());
            check_model("t6_drain");
        end
        idle_inputs();

        // Reset in the middle of a fill
        Icache_valid_out = 1'b1;
        Icache_data_out  = 64'h0123_4567_89AB_CDEF;
        step();
        step();
        check_val("t6_prefill", 64'(queue_count), 64'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        check_reset_outputs("t6_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the instruction cache.
- Drives the cache lookup address from its own fetch PC and consumes the cache's 64-bit hit data: two 32-bit Alpha instructions per line.
- Splits each line into individual instructions and buffers them, with their PCs, in a circular FIFO that dispatch drains one instruction per cycle.
- Flushes and redirects on rollback from the back end.

Parameters:
QUEUE_DEPTH, 8, number of instruction slots; power of two, >= 2
NOOP_INST, 32'h47FF041F, instruction presented when the queue is empty

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
Icache_data_out  input  64  cache line data for proc2Icache_addr
Icache_valid_out  input  1  cache hit, Icache_data_out valid this cycle
rollback_en  input  1  flush queue and redirect fetch
rollback_pc  input  64  redirect target
dispatch_en  input  1  dispatch consumes head instruction this cycle
proc2Icache_addr  output  64  line-aligned fetch address, {fetch_pc[63:3],3'b000}
inst_out  output  32  head instruction
inst_pc_out  output  64  PC of head instruction
inst_valid_out  output  1  queue non-empty
queue_count  output  $clog2(QUEUE_DEPTH)+1  occupancy

Behaviour:
Interface
- One clock, `clock`. `reset` is synchronous and active-high.

Reset
- fetch_pc=0, head=0, tail=0, count=0.
- Queue entries are cleared.
- Outputs after reset: inst_valid_out=0, inst_out=NOOP_INST, inst_pc_out=0, queue_count=0, proc2Icache_addr=0.
- Reset asserted mid-operation discards all queued instructions in that cycle.

Lookup address
- proc2Icache_addr is combinational from the fetch_pc register only.
- It never depends on Icache_* inputs, so there is no combinational loop through the cache.

Enqueue
- n_enq: 2 if fetch_pc[2]==0, else 1.
- The line is accepted when Icache_valid_out && !rollback_en && (QUEUE_DEPTH - count) >= n_enq.
- The room check uses count before this cycle's dequeue. This is conservative and intentional.
- Aligned line (fetch_pc[2]==0):
  - slot tail gets {Icache_data_out[31:0], pc=fetch_pc}.
  - slot tail+1 gets {Icache_data_out[63:32], pc=fetch_pc+4}.
- Unaligned line (fetch_pc[2]==1): slot tail gets {Icache_data_out[63:32], pc=fetch_pc}.
- On accept:
  - tail advances by n_enq, modulo QUEUE_DEPTH.
  - fetch_pc becomes {fetch_pc[63:3]+1, 3'b000}.
- On miss or insufficient room, fetch_pc holds. The same address is re-presented and the fetch retries every cycle.

Dequeue
- Fires when dispatch_en && count!=0 && !rollback_en.
- head advances by 1, modulo QUEUE_DEPTH.
- dispatch_en while empty is ignored; no underflow.
- inst_out and inst_pc_out are registered-entry reads at head.
- When count==0: inst_out=NOOP_INST and inst_pc_out=0.

Occupancy
- count_next = count + accepted n_enq - dequeued.
- Simultaneous enqueue and dequeue is legal.
- count never exceeds QUEUE_DEPTH.
- Pointers wrap naturally.

Rollback (highest priority below reset)
- head=tail=count=0.
- fetch_pc = {rollback_pc[63:2], 2'b00}; bits [1:0] are ignored.
- Same-cycle enqueue and dequeue are suppressed.
- inst_valid_out=0 from the next cycle.
- Fetch from the new PC begins next cycle, so the first redirected instruction can appear 2 cycles after rollback on a cache hit.

Latency
- Cache hit in cycle N → instruction(s) visible at head by cycle N+1 if the queue was empty.

Wrap
- fetch_pc increments across the full 64 bits; no saturation.

Test Plan:
1. Reset, then Icache_valid_out=1 with data 64'hAAAA_AAAA_BBBB_BBBB at fetch_pc 0 → next cycle inst_out=32'hBBBBBBBB, inst_pc_out=0, queue_count=2, proc2Icache_addr=8. Dispatch once → inst_out=32'hAAAAAAAA, pc=4.
2. rollback_pc=64'h104, then a hit → only the high word is enqueued with pc=0x104, queue_count=1, proc2Icache_addr becomes 0x108.
3. Hold hit, no dispatch, QUEUE_DEPTH=8 → count reaches 8 after 4 lines. proc2Icache_addr freezes and queue_count stays 8. Also check count=7 with an aligned hit → stall, because 2 slots are needed.
4. count=8 with a hit, dispatch_en=1 → dequeue only, count=7. Next cycle with an aligned hit and dispatch → accepted only when room >= 2 by pre-dequeue count.
5. Queue holding 5 instructions, rollback_en=1 with rollback_pc=64'h2003 and simultaneous hit and dispatch → next cycle count=0, inst_valid_out=0, inst_out=NOOP_INST, proc2Icache_addr=0x2000, fetch_pc=0x2000.
6. Fill and drain repeatedly so head and tail wrap past QUEUE_DEPTH → FIFO order and PCs are preserved. Also assert reset mid-fill → all outputs take their reset values next cycle.
